// File: rtl/swap_sort_ctrl_if.sv
// Load and drain valid/ready streams of the swap sort controller.
interface swap_sort_ctrl_if #(
  parameter int unsigned W = 8
);
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output load_valid, load_data, out_ready,
    input  load_ready, out_valid, out_data
  );

  modport slave (
    input  load_valid, load_data, out_ready,
    output load_ready, out_valid, out_data
  );
endinterface

// File: rtl/swap_sort_ctrl.sv
// Load N words, sort them with N odd-even transposition passes, drain ascending.
// Optional swap counter enabled by defining SWAP_CNT_EN.
module swap_sort_ctrl #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  swap_sort_ctrl_if.slave         s,
  output logic                    busy,
  output logic                    done
`ifdef SWAP_CNT_EN
  ,
  output logic [$clog2(N*N)-1:0]  swap_cnt
`endif
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
`ifdef SWAP_CNT_EN
  localparam int unsigned CW = $clog2(N*N);
`endif
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  r     [N];
  logic [W-1:0]  r_nxt [N];
  logic [IW-1:0] idx;
  logic [IW-1:0] pass;
  logic          load_hs;
  logic          out_hs;
`ifdef SWAP_CNT_EN
  logic [CW-1:0] nsw;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_hs && idx == LAST)  state_nxt = SORT;
      SORT:    if (pass == LAST)            state_nxt = DRAIN;
      DRAIN:   if (out_hs && idx == LAST)   state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Output decode; load_ready is held low during reset
  always_comb begin
    s.load_ready = 1'b0;
    s.out_valid  = 1'b0;
    s.out_data   = r[idx];
    busy         = 1'b0;
    load_hs      = 1'b0;
    out_hs       = 1'b0;
    done         = 1'b0;
    case (state)
      LOAD: begin
        s.load_ready = ~rst;
        load_hs      = s.load_valid & ~rst;
      end
      SORT:  busy = 1'b1;
      DRAIN: begin
        s.out_valid = 1'b1;
        out_hs      = s.out_ready;
        done        = s.out_ready && idx == LAST;
      end
      default: ;
    endcase
  end

  // One transposition pass: pairs are disjoint, so every compare reads the old words
  always_comb begin
    r_nxt = r;
`ifdef SWAP_CNT_EN
    nsw = '0;
`endif
    for (int k = 0; k < int'(N) - 1; k++) begin
      if (k[0] == pass[0] && r[k] > r[k+1]) begin
        r_nxt[k]   = r[k+1];
        r_nxt[k+1] = r[k];
`ifdef SWAP_CNT_EN
        nsw = nsw + CW'(1);
`endif
      end
    end
  end

  // Word registers, index and pass counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(N); k++) r[k] <= '0;
      idx  <= '0;
      pass <= '0;
`ifdef SWAP_CNT_EN
      swap_cnt <= '0;
`endif
    end else begin
      case (state)
        LOAD: if (load_hs) begin
          r[idx] <= s.load_data;
          idx    <= (idx == LAST) ? '0 : idx + IW'(1);
          pass   <= '0;
`ifdef SWAP_CNT_EN
          if (idx == LAST) swap_cnt <= '0;
`endif
        end
        SORT: begin
          r    <= r_nxt;
          pass <= (pass == LAST) ? '0 : pass + IW'(1);
`ifdef SWAP_CNT_EN
          swap_cnt <= swap_cnt + nsw;
`endif
        end
        DRAIN: if (out_hs) idx <= (idx == LAST) ? '0 : idx + IW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_swap_sort_ctrl.sv
// Scoreboard bench for swap_sort_ctrl (W=8, N=4).
module tb_swap_sort_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic done;
`ifdef SWAP_CNT_EN
  logic [$clog2(N*N)-1:0] swap_cnt;
`endif

  swap_sort_ctrl_if #(.W(W)) bus ();

  swap_sort_ctrl #(.W(W), .N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .s    (bus.slave),
    .busy (busy),
    .done (done)
`ifdef SWAP_CNT_EN
    ,
    .swap_cnt (swap_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  job [4];
  int          exp_sw;
  int          all1 [8] = '{1, 1, 1, 1, 1, 1, 1, 1};
  int          stallp [8] = '{1, 0, 0, 1, 0, 1, 1, 1};

  // Pushes the sorted job and its inversion count, then hands the words over
  task automatic send_words();
    logic [7:0] srt [4];
    logic [7:0] t;
    int         to;
    srt = job;
    exp_sw = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (job[i] > job[j]) exp_sw++;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3 - i; j++)
        if (srt[j] > srt[j+1]) begin t = srt[j]; srt[j] = srt[j+1]; srt[j+1] = t; end
    for (int i = 0; i < 4; i++) exp_q.push_back(srt[i]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_data  = job[i];
      #1;
      to = 0;
      while (!bus.load_ready && to < 50) begin
        @(negedge clk); #1; to++;
      end
      if (to >= 50) begin
        total_cnt++;
        $display("FAIL load_timeout word=%0d load_ready=%b required 1", i, bus.load_ready);
      end
    end
  endtask

  // Counts cycles from the last load handshake until out_valid
  task automatic wait_sort(input bit hold, output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      if (hold) bus.load_data = 8'($urandom);
      else      bus.load_valid = 1'b0;
      #1;
      lat++;
      if (busy) bcnt++;
    end while (!bus.out_valid && lat < 20);
  endtask

  // Drains one job with a cyclic out_ready pattern, checking against the scoreboard
  task automatic drain_job(input int pat [8], input int plen, input bit hold);
    int         got = 0, p = 0, cyc = 0;
    bit         stalled = 1'b0;
    logic [7:0] prev = '0, e;
    while (got < 4 && cyc < 100) begin
      @(negedge clk);
      bus.out_ready = pat[p % plen][0];
      p++; cyc++;
      if (hold) bus.load_data = 8'($urandom);
      #1;
      total_cnt++;
      if (bus.out_valid !== 1'b1) $display("FAIL drain_valid out_valid=%b required 1", bus.out_valid);
      else pass_cnt++;
      if (stalled) begin
        total_cnt++;
        if (bus.out_data !== prev) $display("FAIL stall_stable out_data=%h required %h", bus.out_data, prev);
        else pass_cnt++;
      end
      if (bus.out_ready && bus.out_valid) begin
        got++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total_cnt++;
        if (bus.out_data !== e) $display("FAIL out_data word=%0d got=%h required %h", got, bus.out_data, e);
        else pass_cnt++;
        total_cnt++;
        if (done !== (got == 4)) $display("FAIL done word=%0d done=%b required %b", got, done, got == 4);
        else pass_cnt++;
        if (got == 4) bus.load_valid = 1'b0;
      end
      stalled = bus.out_valid && !bus.out_ready;
      prev    = bus.out_data;
    end
    if (got < 4) begin
      total_cnt++;
      $display("FAIL drain_timeout words=%0d required 4", got);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.load_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL after_drain out_valid=%b load_ready=%b done=%b required 0 1 0",
               bus.out_valid, bus.load_ready, done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if (bus.load_ready !== 1'b0) $display("FAIL reset_load_ready load_ready=%b required 0", bus.load_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_outputs out_valid=%b busy=%b done=%b required 0 0 0", bus.out_valid, busy, done);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk); #1;
    total_cnt++;
    if (bus.load_ready !== 1'b1) $display("FAIL post_reset_ready load_ready=%b required 1", bus.load_ready);
    else pass_cnt++;
`ifdef SWAP_CNT_EN
    total_cnt++;
    if (swap_cnt !== '0) $display("FAIL reset_swap_cnt swap_cnt=%0d required 0", swap_cnt);
    else pass_cnt++;
`endif
  endtask

  task automatic run_job(input string name, input int pat [8], input int plen);
    int lat, bcnt;
    send_words();
    wait_sort(1'b0, lat, bcnt);
    total_cnt++;
    if (lat !== 5) $display("FAIL %s_latency cycles=%0d required 5", name, lat);
    else pass_cnt++;
    total_cnt++;
    if (bcnt !== 4) $display("FAIL %s_busy cycles=%0d required 4", name, bcnt);
    else pass_cnt++;
`ifdef SWAP_CNT_EN
    total_cnt++;
    if (swap_cnt !== 4'(exp_sw)) $display("FAIL %s_swap_cnt swap_cnt=%0d required %0d", name, swap_cnt, exp_sw);
    else pass_cnt++;
`endif
    drain_job(pat, plen, 1'b0);
`ifdef SWAP_CNT_EN
    total_cnt++;
    if (swap_cnt !== 4'(exp_sw)) $display("FAIL %s_swap_hold swap_cnt=%0d required %0d", name, swap_cnt, exp_sw);
    else pass_cnt++;
`endif
  endtask

  task automatic test_basic();
    job = '{8'h04, 8'h03, 8'h02, 8'h01};
    run_job("reverse", all1, 1);
  endtask

  task automatic test_sorted();
    job = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_job("sorted", all1, 1);
  endtask

  task automatic test_extremes();
    job = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    run_job("extremes", all1, 1);
  endtask

  task automatic test_stall();
    job = '{8'h5A, 8'h10, 8'hC3, 8'h77};
    run_job("stall", stallp, 7);
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    job = '{8'h11, 8'h44, 8'h33, 8'h22};
    send_words();
    repeat (3) begin
      @(negedge clk);
      bus.load_valid = 1'b0;
      #1;
      lat++;
    end
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL midsort_busy busy=%b required 1", busy);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.delete();
    total_cnt++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.load_ready !== 1'b1)
      $display("FAIL midsort_reset out_valid=%b busy=%b load_ready=%b required 0 0 1",
               bus.out_valid, busy, bus.load_ready);
    else pass_cnt++;
    job = '{8'h09, 8'h07, 8'h08, 8'h06};
    run_job("after_reset", all1, 1);
  endtask

  task automatic test_hold_valid();
    int lat, bcnt;
    job = '{8'h30, 8'h10, 8'h40, 8'h20};
    send_words();
    wait_sort(1'b1, lat, bcnt);
    total_cnt++;
    if (lat !== 5 || bcnt !== 4) $display("FAIL hold_timing lat=%0d busy=%0d required 5 4", lat, bcnt);
    else pass_cnt++;
    drain_job(stallp, 7, 1'b1);
  endtask

  task automatic test_back_to_back();
    job = '{8'h80, 8'h7F, 8'h81, 8'h01};
    run_job("b2b_a", all1, 1);
    job = '{8'h02, 8'h02, 8'h01, 8'h01};
    run_job("b2b_b", all1, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sorted();
    test_extremes();
    test_stall();
    test_reset_mid();
    test_hold_valid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
